// File: rtl/dff_share_pkg.sv
// Shared types and constants for the shared-register arbiter.
// Optional burst ownership is enabled with the DFF_SHARE_LOCK_EN macro.
package dff_share_pkg;

    localparam int MAX_NREQ = 8;
    localparam int IDX_W_MAX = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // Increment a requester index, wrapping at n.
    function automatic logic [IDX_W_MAX-1:0] wrap_inc(input logic [IDX_W_MAX-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, modulo NREQ.
module rr_pick
    import dff_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic            o_any,
    output logic [IDW-1:0]  o_idx
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = NREQ'(w_req2 >> i_ptr);
    assign o_any  = |w_rot;
    assign w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx  = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : IDW'(w_sum);

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDW'(k);
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// One WIDTH-bit register shared by NREQ requesters with round-robin grants and a settle gap.
// Define DFF_SHARE_LOCK_EN to add req_lock burst ownership.
module dff_share_arbiter
    import dff_share_pkg::*;
#(
    parameter int               NREQ       = 4,
    parameter int               WIDTH      = 3,
    parameter int               SETTLE_CYC = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [2*NREQ-1:0]         req_op,
    input  logic [WIDTH*NREQ-1:0]     req_data,
`ifdef DFF_SHARE_LOCK_EN
    input  logic [NREQ-1:0]           req_lock,
`endif
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          q,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   last_id,
    output logic                      upd,
    output logic                      err,
    output state_e                    dbg_state
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0][1:0]       w_op;
    logic [NREQ-1:0][WIDTH-1:0] w_data;
    logic                       w_any;
    logic [IDW-1:0]             w_pick;
    logic                       w_gnt_valid;
    logic                       w_lock;
    logic [IDW-1:0]             w_gnt_next;
    logic [IDW-1:0]             w_ptr_next;

    state_e           r_state;
    logic [IDW-1:0]   r_gnt_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_last_id;
    logic [WIDTH-1:0] r_q;
    logic             r_upd;
    logic             r_err;
    logic             r_locked;
    logic [3:0]       r_cnt;

    assign w_op        = req_op;
    assign w_data      = req_data;
    assign w_gnt_valid = req_valid[r_gnt_id];
    assign w_gnt_next  = IDW'(wrap_inc(IDX_W_MAX'(r_gnt_id), NREQ));
    assign w_ptr_next  = IDW'(wrap_inc(IDX_W_MAX'(r_rr_ptr), NREQ));
`ifdef DFF_SHARE_LOCK_EN
    assign w_lock = req_lock[r_gnt_id];
`else
    assign w_lock = 1'b0;
`endif

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt_id  <= '0;
            r_rr_ptr  <= '0;
            r_last_id <= '0;
            r_q       <= RESET_VAL;
            r_upd     <= 1'b0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                IDLE: begin
                    // An absent lock owner releases the burst; the scan resumes past it.
                    if (r_locked && !req_valid[r_rr_ptr]) begin
                        r_locked <= 1'b0;
                        r_rr_ptr <= w_ptr_next;
                    end
                    if (w_any) begin
                        r_gnt_id <= w_pick;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_gnt_valid) begin
                        case (op_e'(w_op[r_gnt_id]))
                            OP_WRITE: r_q <= w_data[r_gnt_id];
                            OP_SET:   r_q <= '1;
                            OP_CLR:   r_q <= '0;
                            default:  ;
                        endcase
                        r_last_id <= r_gnt_id;
                        r_upd     <= 1'b1;
                        r_rr_ptr  <= w_lock ? r_gnt_id : w_gnt_next;
                        r_locked  <= w_lock;
                    end else begin
                        r_err <= 1'b1;
                    end
                    if (SETTLE_CYC > 0) begin
                        r_cnt   <= 4'(SETTLE_CYC - 1);
                        r_state <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETTLE: begin
                    if (r_cnt == 4'd0) r_state <= IDLE;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == GRANT) req_ready[r_gnt_id] = 1'b1;
    end

    assign q         = r_q;
    assign busy      = (r_state != IDLE);
    assign last_id   = r_last_id;
    assign upd       = r_upd;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter: latency, round-robin order, opcodes, protocol error, reset abort, lock.
module tb_dff_share_arbiter;
    import dff_share_pkg::*;

    localparam int NREQ = 4;
    localparam int WIDTH = 3;
    localparam int SETTLE_CYC = 1;
    localparam logic [WIDTH-1:0] RESET_VAL = 3'd2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [1:0]            last_id;
    logic                  upd;
    logic                  err;
    state_e                dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int prev_cyc = 0;

    dff_share_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
`ifdef DFF_SHARE_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .q         (q),
        .busy      (busy),
        .last_id   (last_id),
        .upd       (upd),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input op_e op, input logic [WIDTH-1:0] d);
        req_op[2*id +: 2] = op;
        req_data[WIDTH*id +: WIDTH] = d;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_grant(input int id, input string tag);
        int n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    endtask

    task automatic do_txn(input int id, input op_e op, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] exp_q, input string tag);
        set_req(id, op, d);
        wait_grant(id, tag);
        tick();
        req_valid[id] = 1'b0;
        chk({tag, "_q"}, 32'(q), 32'(exp_q));
        chk({tag, "_upd"}, 32'(upd), 32'd1);
        chk({tag, "_last_id"}, 32'(last_id), 32'(id));
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_op = '0;
        req_data = '0;
        req_lock = '0;

        // Reset values and first-transaction latency
        do_reset();
        chk("rst_q", 32'(q), 32'(RESET_VAL));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_id", 32'(last_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        set_req(0, OP_WRITE, 3'd5);
        tick();
        chk("lat_ready", 32'(req_ready), 32'b0001);
        chk("lat_state", 32'(dbg_state), 32'(GRANT));
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_q_hold", 32'(q), 32'(RESET_VAL));
        tick();
        req_valid[0] = 1'b0;
        chk("lat_q", 32'(q), 32'd5);
        chk("lat_upd", 32'(upd), 32'd1);
        chk("lat_last_id", 32'(last_id), 32'd0);
        chk("lat_ready_off", 32'(req_ready), 32'd0);
        tick();
        chk("lat_upd_off", 32'(upd), 32'd0);
        chk("lat_idle", 32'(dbg_state), 32'(IDLE));

        // Four simultaneous requesters served 0,1,2,3 three cycles apart
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, OP_WRITE, 3'(i + 1));
        tick();
        chk("rr0_ready", 32'(req_ready), 32'b0001);
        prev_cyc = cyc;
        tick();
        req_valid[0] = 1'b0;
        chk("rr0_q", 32'(q), 32'd1);
        for (int i = 1; i < NREQ; i++) begin
            wait_grant(i, "rr");
            chk("rr_spacing", 32'(cyc - prev_cyc), 32'd3);
            prev_cyc = cyc;
            tick();
            req_valid[i] = 1'b0;
            chk("rr_q", 32'(q), 32'(i + 1));
            chk("rr_last_id", 32'(last_id), 32'(i));
        end
        chk("rr_final_q", 32'(q), 32'd4);

        // SET, CLEAR, NOP from requester 2 starting at 5
        do_txn(2, OP_WRITE, 3'd5, 3'd5, "op_w5");
        do_txn(2, OP_SET,   3'd0, 3'd7, "op_set");
        do_txn(2, OP_CLR,   3'd6, 3'd0, "op_clr");
        do_txn(2, OP_NOP,   3'd5, 3'd0, "op_nop");

        // Granted requester 1 drops valid during GRANT
        do_reset();
        do_txn(0, OP_WRITE, 3'd3, 3'd3, "pv_pre");
        set_req(1, OP_WRITE, 3'd6);
        wait_grant(1, "pv");
        req_valid[1] = 1'b0;
        tick();
        chk("pv_q", 32'(q), 32'd3);
        chk("pv_err", 32'(err), 32'd1);
        chk("pv_upd", 32'(upd), 32'd0);
        chk("pv_last_id", 32'(last_id), 32'd0);
        tick();
        chk("pv_err_sticky", 32'(err), 32'd1);
        set_req(0, OP_WRITE, 3'd1);
        set_req(1, OP_WRITE, 3'd4);
        wait_grant(1, "pv_ptr");
        tick();
        req_valid[1] = 1'b0;
        chk("pv_ptr_q", 32'(q), 32'd4);
        wait_grant(0, "pv_next");
        tick();
        req_valid[0] = 1'b0;
        chk("pv_next_q", 32'(q), 32'd1);
        chk("pv_err_still", 32'(err), 32'd1);

        // Reset asserted during GRANT of a write of 6
        set_req(0, OP_WRITE, 3'd6);
        wait_grant(0, "ra");
        rst_n = 1'b0;
        tick();
        chk("ra_q", 32'(q), 32'(RESET_VAL));
        chk("ra_state", 32'(dbg_state), 32'(IDLE));
        chk("ra_ready", 32'(req_ready), 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_err", 32'(err), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        chk("ra_q_after", 32'(q), 32'(RESET_VAL));
        chk("ra_upd", 32'(upd), 32'd0);

`ifdef DFF_SHARE_LOCK_EN
        // Requester 3 keeps ownership for three transactions while requester 0 waits
        do_reset();
        do_txn(2, OP_WRITE, 3'd1, 3'd1, "lk_pre");
        set_req(0, OP_WRITE, 3'd1);
        req_lock[3] = 1'b1;
        do_txn(3, OP_WRITE, 3'd4, 3'd4, "lk_a");
        do_txn(3, OP_WRITE, 3'd5, 3'd5, "lk_b");
        do_txn(3, OP_WRITE, 3'd6, 3'd6, "lk_c");
        req_lock[3] = 1'b0;
        wait_grant(0, "lk_rel");
        tick();
        req_valid[0] = 1'b0;
        chk("lk_rel_q", 32'(q), 32'd1);
        chk("lk_rel_last_id", 32'(last_id), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Shares one WIDTH-bit register, with set/clear/load semantics, among NREQ requesters.
- Round-robin arbitration; one update per transaction; a programmable settle gap follows every update.
- Sits between control agents and the shared flop bank. Drives the bank's output `q` and reports which requester last wrote it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 3, width of the shared register.
- SETTLE_CYC, 1, idle cycles forced after each update (0..15).
- RESET_VAL, 0, value of `q` after reset (WIDTH bits).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request; must stay high until its req_ready pulse.
- req_op  in  2*NREQ  per-requester opcode; slice i = [2i+1:2i].
- req_data  in  WIDTH*NREQ  per-requester write data; slice i = [WIDTH*i +: WIDTH].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- q  out  WIDTH  shared register value.
- busy  out  1  high whenever state is not IDLE.
- last_id  out  clog2(NREQ)  index of the requester that last updated q.
- upd  out  1  one-cycle pulse in the cycle after q changes (or after NOP is applied).
- err  out  1  sticky flag: a granted requester dropped req_valid before ready.

Behaviour:
- Reset (rst_n low at a clk edge):
  - q=RESET_VAL; state=IDLE; rr_ptr=0; last_id=0.
  - req_ready=0; upd=0; err=0; settle counter=0.
  - Reset mid-transaction abandons it: q takes RESET_VAL and no partial update occurs.
- FSM states: IDLE, GRANT, SETTLE.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Register it as gnt_id and go to GRANT. Otherwise stay in IDLE.
- GRANT (exactly one cycle):
  - req_ready[gnt_id]=1 combinationally. All other ready bits are 0.
  - If req_valid[gnt_id] is still 1, apply the opcode at this edge:
    - 00 WRITE: q <= data slice.
    - 01 SET: q <= all ones.
    - 10 CLEAR: q <= 0.
    - 11 NOP: q unchanged.
  - On apply also: last_id <= gnt_id; upd <= 1 for the next cycle; rr_ptr <= (gnt_id+1) mod NREQ.
  - If req_valid[gnt_id] is 0 (protocol violation): no update, err <= 1, rr_ptr unchanged.
  - Next state: SETTLE if SETTLE_CYC>0, else IDLE.
- SETTLE:
  - Counter loads SETTLE_CYC-1 on entry and decrements each cycle.
  - Exit to IDLE when it reaches 0. No grants are issued; requests are held off.
- Latency:
  - Valid seen in IDLE at cycle n → ready in cycle n+1 → new q visible in cycle n+2.
  - Minimum request spacing = 2+SETTLE_CYC cycles.
- Simultaneous valids: the round-robin order guarantees no starvation. Worst-case wait = (NREQ-1)·(2+SETTLE_CYC) cycles.
- A requester whose valid rises during GRANT or SETTLE is considered at the next IDLE cycle.
- Opcode and data are sampled only in the GRANT cycle.
- err clears only on reset.

Optional Feature:
- Macro: DFF_SHARE_LOCK_EN.
- Defined:
  - Adds input req_lock [NREQ].
  - If req_lock[gnt_id]=1 in the GRANT cycle, rr_ptr is set to gnt_id instead of gnt_id+1. The same requester then wins the next arbitration if still valid (burst ownership).
  - Lock ends when a GRANT occurs with lock=0, or when the owner's valid is low in IDLE, in which case normal round-robin continues from gnt_id+1.
- Undefined: the port is absent and rr_ptr always advances.

Decomposition:
- Package dff_share_pkg:
  - op_e typedef: OP_WRITE=2'b00, OP_SET=2'b01, OP_CLR=2'b10, OP_NOP=2'b11.
  - state_e typedef: IDLE, GRANT, SETTLE.
  - Constant MAX_NREQ=8.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: any, index.
  - Instantiated once; separately testable.

Test Plan:
- Reset with RESET_VAL=3'd2, then one cycle later req_valid=4'b0001, op WRITE, data 3'd5 → ready[0] in cycle 2, q=5 and upd=1 in cycle 3, last_id=0.
- All four valid at once with ops WRITE 1/2/3/4 (data 3'd1..3'd4), SETTLE_CYC=1 → grants in order 0,1,2,3 spaced 3 cycles apart; final q=4.
- Requester 2 issues SET, then CLEAR, then NOP, with q starting at 3'd5 → q=7, then 0, then 0; upd pulses on all three.
- Requester 1 is granted but drops valid in the GRANT cycle → q unchanged, err=1 and remains 1, rr_ptr stays at 1.
- rst_n driven low in the GRANT cycle of a WRITE of 3'd6 → q=RESET_VAL next cycle, state IDLE, ready low.
- With DFF_SHARE_LOCK_EN: requester 3 holds lock=1 for 3 transactions while requester 0 is valid → grants 3,3,3, then 0 after lock drops.
